instr_fetch_unit: RTL and testbench

- Instruction-side producer paired with the control unit: fetches words from instruction memory, holds the current instruction on Instr, and computes the next PC from the control unit's decoded PCSrc/Jmp/JR/imm fields.
- Sits between the icache/memory port and the control unit; supplies pc_plus4 for JAL linking.
- Halt from the control unit freezes fetch until reset.

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds the
// current instruction for the control unit, and selects the next PC from the
// decoded branch/jump controls. Halt freezes fetch until reset.
// Optional performance counters are enabled with the macro FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [15:0] imm16,
    input  logic        Jmp,
    input  logic [25:0] imm26,
    input  logic        JR,
    input  logic [31:0] jr_target,
    input  logic        Halt,
    output logic [31:0] pc_plus4,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retire_count,
    output logic [31:0] wait_count
`endif
);

    typedef enum logic [1:0] {
        StFetch,
        StIssue,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_seq;
    logic [31:0] br_off;
    logic [31:0] pc_next;

    assign pc_seq = pc_q + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC select: JR beats Jmp beats taken branch beats sequential.
    always_comb begin
        pc_next = pc_seq;
        if (JR) begin
            pc_next = {jr_target[31:2], 2'b00};
        end else if (Jmp) begin
            pc_next = {pc_seq[31:28], imm26, 2'b00};
        end else if (PCSrc) begin
            pc_next = pc_seq + br_off;
        end
    end

    // FSM next state, PC and instruction register updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StFetch: begin
                if (ihit) begin
                    instr_d = iload;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Halt wins over stall and every PC control; PC is frozen.
                if (Halt) begin
                    state_d = StHalted;
                end else if (!stall) begin
                    pc_d    = pc_next;
                    state_d = StFetch;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // State, PC and instruction registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        iREN        = (state_q == StFetch);
        instr_valid = (state_q == StIssue);
        halted      = (state_q == StHalted);
        iaddr       = pc_q;
        pc_plus4    = pc_seq;
        Instr       = instr_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] wait_q, wait_d;

    // Retire on any ISSUE exit; wait on each FETCH cycle without a response.
    always_comb begin
        retire_d = retire_q;
        wait_d   = wait_q;
        if (state_q == StIssue && (Halt || !stall)) begin
            retire_d = retire_q + 32'd1;
        end
        if (state_q == StFetch && !ihit) begin
            wait_d = wait_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            retire_q <= 32'h0;
            wait_q   <= 32'h0;
        end else begin
            retire_q <= retire_d;
            wait_q   <= wait_d;
        end
    end

    assign retire_count = retire_q;
    assign wait_count   = wait_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit (PC_INIT = 0).
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [15:0] imm16 = 16'h0;
    logic        Jmp = 1'b0;
    logic [25:0] imm26 = 26'h0;
    logic        JR = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        Halt = 1'b0;
    logic [31:0] pc_plus4;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_count;
    logic [31:0] wait_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .ihit        (ihit),
        .iload       (iload),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .imm16       (imm16),
        .Jmp         (Jmp),
        .imm26       (imm26),
        .JR          (JR),
        .jr_target   (jr_target),
        .Halt        (Halt),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retire_count(retire_count),
        .wait_count  (wait_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic [31:0] iload;
        logic        stall;
        logic        pcsrc;
        logic [15:0] imm16;
        logic        jmp;
        logic [25:0] imm26;
        logic        jr;
        logic [31:0] jrt;
        logic        halt;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t vecs[35];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_iren, input logic [31:0] e_iaddr,
                              input logic [31:0] e_instr, input logic e_valid,
                              input logic e_halted);
        check32({tag, " iREN"}, {31'h0, iREN}, {31'h0, e_iren});
        check32({tag, " iaddr"}, iaddr, e_iaddr);
        check32({tag, " Instr"}, Instr, e_instr);
        check32({tag, " instr_valid"}, {31'h0, instr_valid}, {31'h0, e_valid});
        check32({tag, " halted"}, {31'h0, halted}, {31'h0, e_halted});
        check32({tag, " pc_plus4"}, pc_plus4, e_iaddr + 32'd4);
    endtask

    // Drive one vector, clock once, then compare post-edge outputs.
    task automatic apply(input vec_t v, input string tag);
        ihit      = v.ihit;
        iload     = v.iload;
        stall     = v.stall;
        PCSrc     = v.pcsrc;
        imm16     = v.imm16;
        Jmp       = v.jmp;
        imm26     = v.imm26;
        JR        = v.jr;
        jr_target = v.jrt;
        Halt      = v.halt;
        @(posedge CLK);
        #1;
        check_outs(tag, v.e_iren, v.e_iaddr, v.e_instr, v.e_valid, v.e_halted);
    endtask

    initial begin
        // ihit iload stall pcsrc imm16 jmp imm26 jr jrt halt | iren iaddr instr valid halted
        vecs[0]  = '{1, 32'hA000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 32'hA000_0000, 1, 0};
        vecs[1]  = '{1, 32'hDEAD_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h4, 32'hA000_0000, 0, 0};
        vecs[2]  = '{1, 32'hA000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h4, 32'hA000_0001, 1, 0};
        vecs[3]  = '{1, 32'hDEAD_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h8, 32'hA000_0001, 0, 0};
        vecs[4]  = '{1, 32'hA000_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h8, 32'hA000_0002, 1, 0};
        vecs[5]  = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h40, 0, 1, 32'h40, 32'hA000_0002, 0, 0};
        vecs[6]  = '{1, 32'hB000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h40, 32'hB000_0000, 1, 0};
        vecs[7]  = '{0, 32'h0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 1, 32'h3C, 32'hB000_0000, 0, 0};
        vecs[8]  = '{1, 32'hB000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h3C, 32'hB000_0001, 1, 0};
        vecs[9]  = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h40, 0, 1, 32'h40, 32'hB000_0001, 0, 0};
        vecs[10] = '{1, 32'hB000_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h40, 32'hB000_0002, 1, 0};
        vecs[11] = '{0, 32'h0, 0, 1, 16'h0003, 0, 26'h0, 0, 32'h0, 0, 1, 32'h50, 32'hB000_0002, 0, 0};
        vecs[12] = '{1, 32'hC000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h50, 32'hC000_0000, 1, 0};
        vecs[13] = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h1000_0010, 0, 1, 32'h1000_0010, 32'hC000_0000, 0, 0};
        vecs[14] = '{1, 32'hC000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h1000_0010, 32'hC000_0001, 1, 0};
        vecs[15] = '{0, 32'h0, 0, 1, 16'h0003, 1, 26'h0000100, 0, 32'h0, 0, 1, 32'h1000_0400, 32'hC000_0001, 0, 0};
        vecs[16] = '{1, 32'hC000_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h1000_0400, 32'hC000_0002, 1, 0};
        vecs[17] = '{0, 32'h0, 0, 1, 16'h0003, 1, 26'h0000100, 1, 32'h0000_2003, 0, 1, 32'h2000, 32'hC000_0002, 0, 0};
        vecs[18] = '{1, 32'hD000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h2000, 32'hD000_0000, 1, 0};
        vecs[19] = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'hD000_0000, 0, 0};
        vecs[20] = '{1, 32'hD000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'hD000_0001, 1, 0};
        vecs[21] = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0, 32'hD000_0001, 0, 0};
        // Memory wait: three cycles without ihit, then a response.
        vecs[22] = '{0, 32'hBAD0_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0, 32'hD000_0001, 0, 0};
        vecs[23] = '{0, 32'hBAD0_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0, 32'hD000_0001, 0, 0};
        vecs[24] = '{0, 32'hBAD0_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0, 32'hD000_0001, 0, 0};
        vecs[25] = '{1, 32'hE000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 32'hE000_0000, 1, 0};
        // Two stall cycles with noisy controls and ihit, then retire.
        vecs[26] = '{1, 32'hBAD0_0003, 1, 1, 16'h0005, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 32'hE000_0000, 1, 0};
        vecs[27] = '{1, 32'hBAD0_0004, 1, 0, 16'h0, 0, 26'h0, 1, 32'h300, 0, 0, 32'h0, 32'hE000_0000, 1, 0};
        vecs[28] = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1, 32'h4, 32'hE000_0000, 0, 0};
        vecs[29] = '{1, 32'hE000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h4, 32'hE000_0001, 1, 0};
        vecs[30] = '{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h20, 0, 1, 32'h20, 32'hE000_0001, 0, 0};
        vecs[31] = '{1, 32'hE000_0002, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h20, 32'hE000_0002, 1, 0};
        // Halt with stall and JR asserted: halt wins, PC frozen at 0x20.
        vecs[32] = '{0, 32'h0, 1, 1, 16'h0001, 0, 26'h0, 1, 32'h100, 1, 0, 32'h20, 32'hE000_0002, 0, 1};
        vecs[33] = '{1, 32'hBAD0_0005, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h20, 32'hE000_0002, 0, 1};
        vecs[34] = '{1, 32'hBAD0_0006, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h20, 32'hE000_0002, 0, 1};

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check_outs("reset", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        nRST = 1'b1;

        for (int i = 0; i < 35; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef FETCH_PERF_CNT_EN
        check32("wait_count", wait_count, 32'd3);
        check32("retire_count", retire_count, 32'd14);
`endif

        // Reset out of HALTED clears the sticky halt.
        #2 nRST = 1'b0;
        #1;
        check_outs("rst_halt", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 nRST = 1'b1;

        // Move to PC 0x80, sit in FETCH, then reset mid-request.
        apply('{1, 32'hF000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0,
                0, 32'h0, 32'hF000_0000, 1, 0}, "seq_a");
        apply('{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h80, 0,
                1, 32'h80, 32'hF000_0000, 0, 0}, "seq_b");
        apply('{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0,
                1, 32'h80, 32'hF000_0000, 0, 0}, "seq_c");
        #2 nRST = 1'b0;
        ihit  = 1'b1;
        iload = 32'hBAD0_0007;
        #1;
        check_outs("rst_mid", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 nRST = 1'b1;
        // Late response after release is taken as the word for PC_INIT.
        apply('{1, 32'hF000_0001, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0,
                0, 32'h0, 32'hF000_0001, 1, 0}, "seq_d");
        apply('{0, 32'h0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0,
                1, 32'h4, 32'hF000_0001, 0, 0}, "seq_e");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
